// File: rtl/fifo_read_pipe.sv
`default_nettype none
//==============================================================================
// Module : fifo_read_pipe
// Brief  : Sync-FIFO output stage. Turns the RAM's one-cycle-latency read into a
//          registered valid/ready stream through a small credit-managed buffer.
// Rev    : 1.0  initial release
//==============================================================================
module fifo_read_pipe #(
    parameter  int DW        = 32,
    parameter  int BUF_DEPTH = 3,
    localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_fifo_valid,
    output logic          o_fifo_ready,
    input  logic [DW-1:0] i_rdata,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_count
);

    localparam int            c_idx_w    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BUF_DEPTH - 1);
    localparam logic [CW-1:0]      c_depth    = CW'(BUF_DEPTH);
    localparam logic [CW:0]        c_depth_ext = (CW + 1)'(BUF_DEPTH);

    logic [DW-1:0]      r_buf [BUF_DEPTH];
    logic [c_idx_w-1:0] r_wr_idx;
    logic [c_idx_w-1:0] r_rd_idx;
    logic [CW-1:0]      r_count;
    logic               r_inflight;

    logic               w_fire;
    logic               w_pop;
    logic [CW:0]        w_occupancy;

    // Explicit wrap so non-power-of-two depths index only valid slots.
    function automatic logic [c_idx_w-1:0] f_next_idx(input logic [c_idx_w-1:0] idx);
        return (idx == c_last_idx) ? '0 : idx + c_idx_w'(1);
    endfunction

    // Credit counts the word still in the RAM pipeline so the buffer can never
    // overflow; it looks only at registers, keeping i_ready off this path.
    assign w_occupancy  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign o_fifo_ready = (w_occupancy < c_depth_ext);
    assign w_fire       = i_fifo_valid & o_fifo_ready;

    assign o_valid = (r_count != '0);
    assign o_data  = r_buf[r_rd_idx];
    assign o_count = r_count;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_fire;
            if (r_inflight) begin
                r_buf[r_wr_idx] <= i_rdata;
                r_wr_idx        <= f_next_idx(r_wr_idx);
            end
            if (w_pop) begin
                r_rd_idx <= f_next_idx(r_rd_idx);
            end
            r_count <= r_count + CW'(r_inflight) - CW'(w_pop);
        end
    end

    property p_no_push_into_full;
        @(posedge i_clk) disable iff (!i_rst_n)
            !(r_inflight && (r_count == c_depth));
    endproperty
    a_no_push_into_full: assert property (p_no_push_into_full);

endmodule
`default_nettype wire
